// File: rtl/truncamiento_q.sv
// Registered reduction of a signed Q(2N-2F).2F product to a saturated Q(N-F).F word.
// Define TRUNC_ROUND_EN to round half up; the default is floor truncation.
module truncamiento_q #(
  parameter int N    = 24,
  parameter int FRAC = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2*N-1:0]   Datos_Sum,
  output logic             out_valid,
  output logic [N-1:0]     Datos_Trunc,
  output logic             ovf,
  output logic             unf
);

  localparam int W = 2 * N;

  logic signed [W:0]   w_ext;
  logic signed [W:0]   w_shift;
  logic        [N+1:0] w_top;
  logic                w_inRange;
  logic                w_neg;
  logic        [N-1:0] w_data;
  logic                w_ovf;
  logic                w_unf;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive extreme.
`ifdef TRUNC_ROUND_EN
  localparam logic signed [W:0] ROUND_C = (W+1)'(1) << (FRAC - 1);
  assign w_ext = $signed({Datos_Sum[W-1], Datos_Sum}) + ROUND_C;
`else
  assign w_ext = $signed({Datos_Sum[W-1], Datos_Sum});
`endif

  assign w_shift = w_ext >>> FRAC;

  // The result fits in N bits only when everything from the output sign bit upward is a sign copy.
  assign w_top     = w_shift[W:N-1];
  assign w_inRange = (&w_top) | ~(|w_top);
  assign w_neg     = w_shift[W];

  always_comb begin
    w_data = w_shift[N-1:0];
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (!w_inRange) begin
      if (w_neg) begin
        w_data = {1'b1, {(N-1){1'b0}}};
        w_unf  = 1'b1;
      end else begin
        w_data = {1'b0, {(N-1){1'b1}}};
        w_ovf  = 1'b1;
      end
    end
  end

  logic [N-1:0] r_data;
  logic         r_valid;
  logic         r_ovf;
  logic         r_unf;

  // Data and flags only advance on a valid sample so the last result stays visible between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_data;
        r_ovf  <= w_ovf;
        r_unf  <= w_unf;
      end
    end
  end

  assign Datos_Trunc = r_data;
  assign out_valid   = r_valid;
  assign ovf         = r_ovf;
  assign unf         = r_unf;

endmodule

// File: tb/tb_truncamiento_q.sv
// Scoreboard bench for truncamiento_q: expected results are queued at drive time and checked one clock later.
// Honours TRUNC_ROUND_EN for the rounding-sensitive directed cases and the reference model.
module tb_truncamiento_q;

  localparam int N    = 24;
  localparam int FRAC = 10;

  typedef struct {
    logic [N-1:0] d;
    logic         o;
    logic         u;
  } expT;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [2*N-1:0] Datos_Sum;
  logic           out_valid;
  logic [N-1:0]   Datos_Trunc;
  logic           ovf;
  logic           unf;

  int errCount;
  int checkCount;
  expT scoreQ[$];
  expT lastExp;

  truncamiento_q #(.N(N), .FRAC(FRAC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .Datos_Sum  (Datos_Sum),
    .out_valid  (out_valid),
    .Datos_Trunc(Datos_Trunc),
    .ovf        (ovf),
    .unf        (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [47:0] actual, input logic [47:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Independent reference: wide signed integer arithmetic with explicit range limits.
  function automatic expT modelRef(input logic [2*N-1:0] s);
    expT    e;
    longint v;
    longint t;
    longint maxV;
    longint minV;
    maxV = (longint'(1) <<< (N - 1)) - 1;
    minV = -(longint'(1) <<< (N - 1));
    v = longint'($signed(s));
`ifdef TRUNC_ROUND_EN
    v = v + (longint'(1) <<< (FRAC - 1));
`endif
    t = v >>> FRAC;
    e.o = 1'b0;
    e.u = 1'b0;
    if (t > maxV) begin
      e.d = maxV[N-1:0];
      e.o = 1'b1;
    end else if (t < minV) begin
      e.d = minV[N-1:0];
      e.u = 1'b1;
    end else begin
      e.d = t[N-1:0];
    end
    return e;
  endfunction

  // Drive one valid sample, queue its expected result, then check one clock later.
  task automatic applyStimulus(input string tag, input logic [2*N-1:0] s, input expT e);
    expT got;
    in_valid  = 1'b1;
    Datos_Sum = s;
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    got = scoreQ.pop_front();
    lastExp = got;
    checkOutput({tag, "_valid"}, 48'(out_valid), 48'(1'b1));
    checkOutput({tag, "_data"},  48'(Datos_Trunc), 48'(got.d));
    checkOutput({tag, "_ovf"},   48'(ovf), 48'(got.o));
    checkOutput({tag, "_unf"},   48'(unf), 48'(got.u));
  endtask

  function automatic expT mk(input logic [N-1:0] d, input logic o, input logic u);
    expT e;
    e.d = d;
    e.o = o;
    e.u = u;
    return e;
  endfunction

  initial begin
    logic [2*N-1:0] s;
    errCount   = 0;
    checkCount = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    Datos_Sum  = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data",  48'(Datos_Trunc), 48'h0);
    checkOutput("reset_valid", 48'(out_valid), 48'h0);
    checkOutput("reset_ovf",   48'(ovf), 48'h0);
    checkOutput("reset_unf",   48'(unf), 48'h0);
    rst = 1'b0;

    applyStimulus("pos_one", 48'h000000100000, mk(24'h000400, 1'b0, 1'b0));
    applyStimulus("neg_one", 48'hFFFFFFF00000, mk(24'hFFFC00, 1'b0, 1'b0));
`ifdef TRUNC_ROUND_EN
    applyStimulus("floor_m1",  48'hFFFFFFFFFFFF, mk(24'h000000, 1'b0, 1'b0));
    applyStimulus("floor_half", 48'h000000000200, mk(24'h000001, 1'b0, 1'b0));
`else
    applyStimulus("floor_m1",  48'hFFFFFFFFFFFF, mk(24'hFFFFFF, 1'b0, 1'b0));
    applyStimulus("floor_half", 48'h000000000200, mk(24'h000000, 1'b0, 1'b0));
`endif
    applyStimulus("sat_pos",   48'h000200000000, mk(24'h7FFFFF, 1'b1, 1'b0));
    applyStimulus("sat_neg",   48'h800000000000, mk(24'h800000, 1'b0, 1'b1));
    applyStimulus("max_pos",   48'h7FFFFFFFFFFF, mk(24'h7FFFFF, 1'b1, 1'b0));
    applyStimulus("exact_max", 48'h0001FFFFFC00, mk(24'h7FFFFF, 1'b0, 1'b0));
    applyStimulus("exact_min", 48'hFFFE00000000, mk(24'h800000, 1'b0, 1'b0));

    // Back-to-back stream mixing full-range and near-range values.
    for (int i = 0; i < 5000; i++) begin
      case ($urandom_range(0, 2))
        0: s = {16'($urandom), $urandom};
        1: s = 48'($signed(35'({3'($urandom), $urandom})));
        default: s = 48'($signed(36'({4'($urandom), $urandom})));
      endcase
      applyStimulus("stream", s, modelRef(s));
    end

    in_valid  = 1'b0;
    Datos_Sum = 48'h000000100000;
    @(posedge clk);
    #1;
    checkOutput("gap_valid", 48'(out_valid), 48'h0);
    checkOutput("gap_data",  48'(Datos_Trunc), 48'(lastExp.d));
    checkOutput("gap_ovf",   48'(ovf), 48'(lastExp.o));
    checkOutput("gap_unf",   48'(unf), 48'(lastExp.u));

    applyStimulus("resume", 48'h000200000000, mk(24'h7FFFFF, 1'b1, 1'b0));

    in_valid  = 1'b1;
    rst       = 1'b1;
    Datos_Sum = 48'h800000000000;
    @(posedge clk);
    #1;
    checkOutput("midrst_data",  48'(Datos_Trunc), 48'h0);
    checkOutput("midrst_valid", 48'(out_valid), 48'h0);
    checkOutput("midrst_ovf",   48'(ovf), 48'h0);
    checkOutput("midrst_unf",   48'(unf), 48'h0);
    rst      = 1'b0;
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
